dvi_tx_timing: RTL
==================

# dvi_tx_timing

Synthesizable CH7301C driver: generates the DVI/VGA raster timing (H, V, DE) and streams RGB555 pixels in the IDF=3 8-bit-multiplexed DDR format. Sits between the frame-buffer pixel FIFO (ready/valid) and the FPGA output stage. Each pixel is emitted as two 12-bit half-words, `dvi_data_rise` and `dvi_data_fall`, which ODDR primitives outside this block place on `dvi_data`. The block also owns the chip's active-low reset pin.

## Interface
- H_FRONT_PORCH, 24, pixels after DE before next line's hsync
- H_SYNC_PULSE, 136, hsync width in pixels
- H_BACK_PORCH, 160, pixels from hsync end to DE
- H_VISIBLE, 1024, DE width in pixels
- V_FRONT_PORCH, 3, blank lines after last visible line
- V_SYNC_PULSE, 6, lines with vsync asserted
- V_BACK_PORCH, 29, blank lines after vsync
- V_VISIBLE, 768, visible lines
- SYNC_POLARITY, 0, 0 = active-low H/V, 1 = active-high
- RESET_HOLD, 16, cycles `dvi_reset_b` stays low after `rst` falls
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- pixel_data  in  15  {R[4:0], G[4:0], B[4:0]}
- pixel_valid  in  1  pixel_data valid
- pixel_ready  out  1  block consumes a pixel this cycle
- frame_start  out  1  one-cycle pulse at start of each frame
- underflow  out  1  sticky; a pixel was needed while pixel_valid = 0
- dvi_data_rise  out  12  half-word for the rising edge (P0b)
- dvi_data_fall  out  12  half-word for the falling edge (P0a)
- dvi_de  out  1  data enable
- dvi_h  out  1  hsync
- dvi_v  out  1  vsync
- dvi_reset_b  out  1  chip reset, active low

## Operation
- H_TOTAL = sum of the H params (1344). V_TOTAL = sum of the V params (806).
- Counters: `h_cnt` runs 0..H_TOTAL-1 and wraps. `v_cnt` increments on the h wrap and runs 0..V_TOTAL-1, then wraps.
- Line classes by `v_cnt`:
  - `[0, VS)`: vsync line. V is asserted for the whole line. H and DE are never asserted.
  - `[VS, VS+VBP)`: blank line. Nothing is asserted.
  - `[VS+VBP, VS+VBP+V_VISIBLE)`: visible line.
    - `h_cnt < HS`: H asserted.
    - `HS+HBP ≤ h_cnt < HS+HBP+H_VISIBLE`: DE asserted.
    - Remainder of the line is blank (front porch).
  - Remaining lines: front-porch lines. Nothing is asserted.
- At most one of H, V, DE is asserted on any cycle.
- Asserted level of H and V is SYNC_POLARITY; deasserted level is its inverse.
- Pixel handshake:
  - `pixel_ready` is high exactly on the cycles where the counters are in the DE region.
  - A pixel is consumed on those cycles regardless of `pixel_valid`.
  - If `pixel_valid` = 0 while `pixel_ready` = 1: that pixel is output as 0 (black) and `underflow` is set. Only `rst` clears `underflow`.
- Packing (bits [3:0] of both words are 0):
  - `dvi_data_rise[10:6]` = R, `[5:4]` = G[4:3], `[11]` = 0.
  - `dvi_data_fall[11:9]` = G[2:0], `[8:4]` = B.
  - Outside DE, both words are 0.
- `frame_start` pulses when `h_cnt` = 0 and `v_cnt` = 0, aligned with the first cycle V is asserted on the outputs.
- Reset sequencing:
  - While `rst` = 1, everything is held in reset.
  - After `rst` falls, a hold counter runs RESET_HOLD cycles with `dvi_reset_b` = 0 and the counters frozen at 0.
  - Then `dvi_reset_b` goes to 1 and the raster starts at `h_cnt` = 0, `v_cnt` = 0.

## Timing
- Reset values (during `rst` and the hold period):
  - `dvi_de` = 0; `dvi_h` = `dvi_v` = ~SYNC_POLARITY; data words = 0.
  - `pixel_ready` = 0; `frame_start` = 0; `underflow` = 0; `dvi_reset_b` = 0.
- `pixel_ready` is combinational from the counters.
- All `dvi_*` outputs and `frame_start` are registered: one cycle after the counter state that produced them. The pixel accepted on cycle N appears on the data words on cycle N+1, together with DE = 1.
- `rst` asserted mid-frame:
  - Next cycle: all outputs return to reset values and counters go to 0.
  - No partial line is completed.
  - The RESET_HOLD sequence repeats.
- Counter wrap: H_TOTAL-1 → 0 and V_TOTAL-1 → 0 in the same cycle, with no idle cycle inserted.

## Test plan
- Small config (H: FP 2, SP 3, BP 2, VIS 4, total 11; V: FP 1, SP 1, BP 1, VIS 2, total 5), SYNC_POLARITY = 0, RESET_HOLD = 4:
  - After reset, `dvi_reset_b` rises after exactly 4 cycles.
  - V is low for 11 cycles, then 11 blank cycles.
  - Then, per visible line: H low for 3 cycles, 2 blank, DE for 4, 2 blank. Two such lines, then 11 blank cycles.
  - Frame period is 55 cycles.
- Same config, pixel stream 0x7FFF, 0x001F, 0x03E0, 0x7C00 held valid:
  - Rise/fall words are 0x7F0/0xFF0, 0x000/0x1F0, 0x030/0xE00, 0x7C0/0x000.
  - These are on DE cycles only; data is 0 elsewhere.
- `pixel_valid` dropped for the 2nd pixel of a line:
  - That pixel outputs 0/0 and `underflow` goes to 1 and stays 1 across frames.
  - Timing is unchanged.
- SYNC_POLARITY = 1: H/V idle low and pulse high with the same widths. A checker confirms H, V and DE are never co-asserted over 3 frames.
- `rst` pulsed at `v_cnt` = 3, `h_cnt` = 5: outputs go to reset values next cycle, and after RESET_HOLD the first `frame_start` occurs with V asserted.
- Default 1024x768 config run through the CH7301C bench model: zero timing errors, and 2 frames of 1024×768 pixels are captured matching the injected pattern.

Source files
------------

// File: rtl/dvi_tx_timing_if.sv
// rtl/dvi_tx_timing_if.sv - pixel FIFO ready/valid stream into the CH7301C driver
interface dvi_tx_timing_if;
   logic [14:0] pixel_data;
   logic        pixel_valid;
   logic        pixel_ready;

   modport master (output pixel_data, output pixel_valid, input pixel_ready);
   modport slave  (input pixel_data, input pixel_valid, output pixel_ready);
endinterface

// File: rtl/dvi_tx_timing.sv
// rtl/dvi_tx_timing.sv - CH7301C raster timing and IDF=3 RGB555 DDR half-word packer
module dvi_tx_timing #(
   parameter int   H_FRONT_PORCH = 24,
   parameter int   H_SYNC_PULSE  = 136,
   parameter int   H_BACK_PORCH  = 160,
   parameter int   H_VISIBLE     = 1024,
   parameter int   V_FRONT_PORCH = 3,
   parameter int   V_SYNC_PULSE  = 6,
   parameter int   V_BACK_PORCH  = 29,
   parameter int   V_VISIBLE     = 768,
   parameter logic SYNC_POLARITY = 1'b0,
   parameter int   RESET_HOLD    = 16
) (
   input  logic               clk,
   input  logic               rst,
   dvi_tx_timing_if.slave     pix,
   output logic               frame_start,
   output logic               underflow,
   output logic [11:0]        dvi_data_rise,
   output logic [11:0]        dvi_data_fall,
   output logic               dvi_de,
   output logic               dvi_h,
   output logic               dvi_v,
   output logic               dvi_reset_b
);
   localparam int H_TOTAL = H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH + H_VISIBLE;
   localparam int V_TOTAL = V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH + V_VISIBLE;
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int RW = $clog2(RESET_HOLD + 1);

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC_PULSE);
   localparam logic [HW-1:0] H_DE_START  = HW'(H_SYNC_PULSE + H_BACK_PORCH);
   localparam logic [HW-1:0] H_DE_END    = HW'(H_SYNC_PULSE + H_BACK_PORCH + H_VISIBLE);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC_PULSE);
   localparam logic [VW-1:0] V_VIS_START = VW'(V_SYNC_PULSE + V_BACK_PORCH);
   localparam logic [VW-1:0] V_VIS_END   = VW'(V_SYNC_PULSE + V_BACK_PORCH + V_VISIBLE);
   localparam logic [RW-1:0] HOLD_LAST   = RW'(RESET_HOLD - 1);

   typedef enum logic [0:0] {S_HOLD, S_RUN} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   hold_q, hold_d;
   logic [HW-1:0]   h_cnt;
   logic [VW-1:0]   v_cnt;
   logic            running;
   logic            vis_line;
   logic            h_act, v_act, de_act;
   logic [14:0]     px;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_HOLD;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_RUN;
            else                     hold_d  = hold_q + RW'(1);
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_HOLD;
      endcase
   end

   assign running = (state_q == S_RUN);

   // Counters stay frozen at the origin until the chip has been released.
   always_ff @(posedge clk) begin
      if (rst || !running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign vis_line = (v_cnt >= V_VIS_START) && (v_cnt < V_VIS_END);
   assign v_act    = running && (v_cnt < V_SYNC_END);
   assign h_act    = running && vis_line && (h_cnt < H_SYNC_END);
   assign de_act   = running && vis_line && (h_cnt >= H_DE_START) && (h_cnt < H_DE_END);

   assign pix.pixel_ready = de_act;
   assign px = pix.pixel_valid ? pix.pixel_data : 15'h0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         dvi_de        <= 1'b0;
         dvi_h         <= ~SYNC_POLARITY;
         dvi_v         <= ~SYNC_POLARITY;
         frame_start   <= 1'b0;
         dvi_reset_b   <= 1'b0;
         dvi_data_rise <= '0;
         dvi_data_fall <= '0;
         underflow     <= 1'b0;
      end else begin
         dvi_de        <= de_act;
         dvi_h         <= h_act ? SYNC_POLARITY : ~SYNC_POLARITY;
         dvi_v         <= v_act ? SYNC_POLARITY : ~SYNC_POLARITY;
         frame_start   <= v_act && (h_cnt == '0) && (v_cnt == '0);
         dvi_reset_b   <= (state_d == S_RUN);
         // P0b carries R and G[4:3]; P0a carries G[2:0] and B.
         dvi_data_rise <= de_act ? {1'b0, px[14:10], px[9:8], 4'h0} : 12'h000;
         dvi_data_fall <= de_act ? {px[7:5], px[4:0], 4'h0} : 12'h000;
         if (de_act && !pix.pixel_valid) underflow <= 1'b1;
      end
   end
endmodule
